// File: rtl/maxpool_stream_if.sv
// Stream bundle for maxpool_stream: pixel input handshake and pooled-pixel output handshake.
// "slave" is the pooling stage; "master" is the surrounding environment (upstream source plus
// downstream sink). With MAXPOOL_ARGMAX_EN defined, the bundle also carries out_argmax.
interface maxpool_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]            out_argmax;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_argmax
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_argmax
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
`endif
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max-pooling stage for unsigned post-ReLU pixels in raster order.
// Even input rows store horizontal-pair maxima in a half-width row buffer; odd input rows
// combine their own pair maxima with the buffered ones and emit one pooled pixel per window.
// Optional feature macro: MAXPOOL_ARGMAX_EN adds out_argmax (0=TL, 1=TR, 2=BL, 3=BR).
module maxpool_stream #(
  parameter int IN_HEIGHT  = 512,
  parameter int IN_WIDTH   = 512,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              start,
  maxpool_stream_if.slave   bus,
  output logic              done_pool
);

  localparam int OUT_HEIGHT = IN_HEIGHT / 2;
  localparam int OUT_WIDTH  = IN_WIDTH / 2;
  localparam int ROW_W      = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int COL_W      = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int IDX_W      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'(2 * OUT_HEIGHT - 1);
  localparam logic [COL_W-1:0] OCOL_LAST = COL_W'(2 * OUT_WIDTH - 1);

`ifdef MAXPOOL_ARGMAX_EN
  // Row-buffer entry carries the even-row pair winner (0=left, 1=right) above the max.
  localparam int ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [ROW_W-1:0]      in_row;
  logic [COL_W-1:0]      in_col;
  logic [DATA_WIDTH-1:0] hold;
  logic [ENTRY_W-1:0]    rowbuf [OUT_WIDTH];
  logic                  in_complete;
  logic                  last_sent;

  logic                  run_ok;
  logic                  beat;
  logic                  pool_fire;
  logic                  pool_last;
  logic                  last_in_beat;
  logic                  last_out_hs;
  logic                  frame_end;
  logic [IDX_W-1:0]      buf_idx;

  logic                  pair_right;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [ENTRY_W-1:0]    pair_entry;
  logic [ENTRY_W-1:0]    top_entry;
  logic [DATA_WIDTH-1:0] top_max;
  logic                  bot_wins;
  logic [DATA_WIDTH-1:0] pool_max;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]            pool_arg;
`endif

  // Handshake and frame-position qualifiers.
  // Once the final input beat is in, the stage stops accepting until the frame closes, so a
  // following frame cannot leak into this one while the last pooled pixel waits for out_ready.
  assign bus.in_ready = run_ok && (!bus.out_valid || bus.out_ready);
  assign beat         = bus.in_valid && bus.in_ready;
  assign pool_fire    = beat && in_col[0] && in_row[0];
  assign pool_last    = (in_row == OROW_LAST) && (in_col == OCOL_LAST);
  assign last_in_beat = beat && (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign last_out_hs  = bus.out_valid && bus.out_ready && bus.out_last;
  assign frame_end    = (last_sent || last_out_hs) && (in_complete || last_in_beat);
  assign buf_idx      = IDX_W'(in_col >> 1);

  // Pair and window maxima; strict greater-than keeps ties on the lower window index.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    pair_right = bus.in_data > hold;
    pair_max   = pair_right ? bus.in_data : hold;
`ifdef MAXPOOL_ARGMAX_EN
    pair_entry = {pair_right, pair_max};
`else
    pair_entry = pair_max;
`endif
    top_entry  = rowbuf[buf_idx];
    top_max    = top_entry[DATA_WIDTH-1:0];
    bot_wins   = pair_max > top_max;
    pool_max   = bot_wins ? pair_max : top_max;
`ifdef MAXPOOL_ARGMAX_EN
    pool_arg   = bot_wins ? {1'b1, pair_right} : {1'b0, top_entry[DATA_WIDTH]};
`endif
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; a low enable overrides everything, including start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (frame_end) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    run_ok    = 1'b0;
    done_pool = 1'b0;
    case (state)
      RUN:     run_ok = en && !in_complete;
      DONE:    done_pool = 1'b1;
      default: ;
    endcase
  end

  // Raster position of the next input beat; held at zero outside an active frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_row <= '0;
      in_col <= '0;
    end else if (!en || state != RUN) begin
      in_row <= '0;
      in_col <= '0;
    end else if (beat) begin
      if (in_col == COL_LAST) begin
        in_col <= '0;
        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Frame-completion flags: all input consumed, and the out_last beat accepted downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_complete <= 1'b0;
      last_sent   <= 1'b0;
    end else if (!en || state != RUN) begin
      in_complete <= 1'b0;
      last_sent   <= 1'b0;
    end else begin
      if (last_in_beat) in_complete <= 1'b1;
      if (last_out_hs)  last_sent   <= 1'b1;
    end
  end

  // Even-column hold register and even-row pair buffer.
  // NOTE: pure datapath storage, left unreset; every entry is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (beat && !in_col[0])             hold            <= bus.in_data;
    if (beat && in_col[0] && !in_row[0]) rowbuf[buf_idx] <= pair_entry;
  end

  // Output register: holds until accepted, and can reload in the same cycle it is drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      bus.out_argmax <= 2'd0;
`endif
    end else if (!en) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
    end else if (pool_fire) begin
      bus.out_valid  <= 1'b1;
      bus.out_data   <= pool_max;
      bus.out_last   <= pool_last;
`ifdef MAXPOOL_ARGMAX_EN
      bus.out_argmax <= pool_arg;
`endif
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed testbench for maxpool_stream: a 4x4 instance and a 5x5 instance share the stimulus
// buses; each has its own en/start and sel picks which one is observed. Expected pooled
// pixels are hand-computed per frame and compared against what the output monitor collects.
module tb_maxpool_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en4, en5, start4, start5;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          done4, done5;
  bit            sel;

  int errors = 0;
  int checks = 0;

  maxpool_stream_if #(.DATA_WIDTH(DW)) if4 ();
  maxpool_stream_if #(.DATA_WIDTH(DW)) if5 ();

  assign if4.in_valid  = in_valid;
  assign if4.in_data   = in_data;
  assign if4.out_ready = out_ready;
  assign if5.in_valid  = in_valid;
  assign if5.in_data   = in_data;
  assign if5.out_ready = out_ready;

  maxpool_stream #(.IN_HEIGHT(4), .IN_WIDTH(4), .DATA_WIDTH(DW)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en4),
    .start     (start4),
    .bus       (if4),
    .done_pool (done4)
  );

  maxpool_stream #(.IN_HEIGHT(5), .IN_WIDTH(5), .DATA_WIDTH(DW)) dut5 (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en5),
    .start     (start5),
    .bus       (if5),
    .done_pool (done5)
  );

  always #5 clk = ~clk;

  // Observed instance.
  logic          obs_in_ready, obs_valid, obs_last, obs_done;
  logic [DW-1:0] obs_data;
  logic [1:0]    obs_arg;
  assign obs_in_ready = sel ? if5.in_ready  : if4.in_ready;
  assign obs_valid    = sel ? if5.out_valid : if4.out_valid;
  assign obs_last     = sel ? if5.out_last  : if4.out_last;
  assign obs_data     = sel ? if5.out_data  : if4.out_data;
  assign obs_done     = sel ? done5 : done4;
`ifdef MAXPOOL_ARGMAX_EN
  assign obs_arg      = sel ? if5.out_argmax : if4.out_argmax;
`else
  assign obs_arg      = 2'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: samples at negedge, where a valid&&ready pair will handshake on the next edge.
  int            got_q[$];
  int            exp_q[$];
  bit            mon_en = 1'b0;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            expect_done;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_hold   = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        check("done_after_last", obs_done, 1);
        expect_done = 1'b0;
      end
      if (prev_hold) begin
        check("hold_valid", obs_valid, 1);
        check("hold_data", obs_data, prev_data);
        check("hold_last", obs_last, prev_last);
      end
      if (obs_valid && out_ready) begin
        got_q.push_back(int'(obs_data) | (int'(obs_last) << 8) | (int'(obs_arg) << 9));
        if (obs_last && !sel) expect_done = 1'b1;
      end
      prev_hold = obs_valid && !out_ready;
      prev_data = obs_data;
      prev_last = obs_last;
    end
  end

  int pix[32];

  function automatic void expect_px(input int d, input int l, input int a);
    exp_q.push_back(d | (l << 8) | (a << 9));
  endfunction

  task automatic start_frame(input bit which);
    sel = which;
    if (which) start5 = 1'b1;
    else       start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start5 = 1'b0;
  endtask

  // Streams pix[0..n-1]; optionally toggles out_ready every cycle. Bounded by a cycle budget.
  task automatic run_frame(input string tag, input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 400) begin
      in_valid  = 1'b1;
      in_data   = DW'(pix[idx]);
      out_ready = toggle ? ~out_ready : 1'b1;
      @(negedge clk);
      if (obs_in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_beats"}, idx, n);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!obs_done && c < 50) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, obs_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i] & 'hFF, exp_q[i] & 'hFF);
      check($sformatf("%s_last%0d", tag, i), (got_q[i] >> 8) & 1, (exp_q[i] >> 8) & 1);
`ifdef MAXPOOL_ARGMAX_EN
      check($sformatf("%s_argmax%0d", tag, i), (got_q[i] >> 9) & 3, (exp_q[i] >> 9) & 3);
`endif
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    en4       = 1'b0;
    en5       = 1'b0;
    start4    = 1'b0;
    start5    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sel       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_in_ready", obs_in_ready, 0);
    check("rst_out_valid", obs_valid, 0);
    check("rst_out_last", obs_last, 0);
    check("rst_done_pool", obs_done, 0);
    check("rst_out_data", obs_data, 0);

    reset_n = 1'b1;
    en4     = 1'b1;
    en5     = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 4x4 ramp 0..15, downstream always ready.
    for (int i = 0; i < 16; i++) pix[i] = i;
    expect_px(5, 0, 3); expect_px(7, 0, 3); expect_px(13, 0, 3); expect_px(15, 1, 3);
    start_frame(1'b0);
    run_frame("ramp", 16, 1'b0);
    wait_done("ramp");
    compare_outputs("ramp");

    // Same frame with out_ready toggling; monitor checks outputs hold while stalled.
    expect_px(5, 0, 3); expect_px(7, 0, 3); expect_px(13, 0, 3); expect_px(15, 1, 3);
    start_frame(1'b0);
    run_frame("toggle", 16, 1'b1);
    wait_done("toggle");
    compare_outputs("toggle");

    // 5x5 ones with 200 in the ignored corner: last row/col consumed but never pooled.
    for (int i = 0; i < 25; i++) pix[i] = 1;
    pix[24] = 200;
    expect_px(1, 0, 0); expect_px(1, 0, 0); expect_px(1, 0, 0); expect_px(1, 1, 0);
    start_frame(1'b1);
    run_frame("odd", 25, 1'b0);
    wait_done("odd");
    check("odd_in_ready_in_done", obs_in_ready, 0);
    compare_outputs("odd");

    // Abort after 6 beats by dropping en, then restart with an all-0xFF frame.
    for (int i = 0; i < 6; i++) pix[i] = 50 + i;
    start_frame(1'b0);
    run_frame("abort", 6, 1'b0);
    en4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_out_valid", obs_valid, 0);
    check("abort_in_ready", obs_in_ready, 0);
    check("abort_done_pool", obs_done, 0);
    got_q.delete();
    en4 = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = 255;
    expect_px(255, 0, 0); expect_px(255, 0, 0); expect_px(255, 0, 0); expect_px(255, 1, 0);
    start_frame(1'b0);
    run_frame("restart", 16, 1'b0);
    wait_done("restart");
    compare_outputs("restart");

    // Window-position frame: {9,3;9,9} {1,2;3,4} / {2,8;8,1} {3,1;6,6}.
    pix[0]  = 9; pix[1]  = 3; pix[2]  = 1; pix[3]  = 2;
    pix[4]  = 9; pix[5]  = 9; pix[6]  = 3; pix[7]  = 4;
    pix[8]  = 2; pix[9]  = 8; pix[10] = 3; pix[11] = 1;
    pix[12] = 8; pix[13] = 1; pix[14] = 6; pix[15] = 6;
    expect_px(9, 0, 0); expect_px(4, 0, 3); expect_px(8, 0, 1); expect_px(6, 1, 2);
    start_frame(1'b0);
    run_frame("window", 16, 1'b0);
    wait_done("window");
    compare_outputs("window");

    // Asynchronous reset mid-frame while a pooled pixel is pending.
    mon_en = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = i;
    start_frame(1'b0);
    run_frame("arst", 6, 1'b0);
    check("arst_pre_out_valid", obs_valid, 1);
    check("arst_pre_out_data", obs_data, 5);
    check("arst_pre_in_ready", obs_in_ready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", obs_valid, 0);
    check("arst_done_pool", obs_done, 0);
    check("arst_in_ready", obs_in_ready, 0);
    check("arst_out_last", obs_last, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
